// File: rtl/video_timing_out.sv
// video_timing_out: programmable H/V raster generator that pulls pixels from the
// VDMA read port (sfetch -> sdata/svalid FETCH_LAT clocks later) and drives split
// RGB, syncs, blanks and active_video, with a sticky underflow flag.
// Build option: define VIDEO_TIMING_OUT_TESTPAT_EN to add the 'testpat' input,
// which replaces fetched pixels by eight vertical colour bars for a whole frame.
module video_timing_out #(
  parameter int R_W       = 5,
  parameter int G_W       = 6,
  parameter int B_W       = 5,
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 13,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 29,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int FETCH_LAT = 2
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic                     en,
  input  logic [R_W+G_W+B_W-1:0]   sdata,
  input  logic                     svalid,
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
  input  logic                     testpat,
`endif
  output logic                     sfetch,
  output logic                     snextframe,
  output logic [R_W-1:0]           video_r,
  output logic [G_W-1:0]           video_g,
  output logic [B_W-1:0]           video_b,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     hblank,
  output logic                     vblank,
  output logic                     active_video,
  output logic                     underflow,
  input  logic                     underflow_clr
);

  localparam int   PIXEL_W      = R_W + G_W + B_W;
  localparam int   H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HC_W         = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int   VC_W         = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int   H_SYNC_START = H_ACTIVE + H_FP;
  localparam int   V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic HS_ON        = (HS_POL != 0);
  localparam logic VS_ON        = (VS_POL != 0);

  typedef enum logic {IDLE, RUN} state_t;

  // Timing attributes of one raster position, carried alongside the fetch latency.
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       hb;
    logic       vb;
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
    logic       tp;
    logic [2:0] bar;
`endif
  } tim_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [VC_W-1:0]   vcnt_q, vcnt_d;
  logic              run, line_end, frame_end;
  tim_t              tim_p0, tim_idle, tap;
  tim_t              dly_q [FETCH_LAT];
  tim_t              dly_d [FETCH_LAT];
  logic [R_W-1:0]    video_r_q, video_r_d;
  logic [G_W-1:0]    video_g_q, video_g_d;
  logic [B_W-1:0]    video_b_q, video_b_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              hblank_q, hblank_d, vblank_q, vblank_d;
  logic              active_video_q, active_video_d;
  logic              underflow_q, underflow_d, miss;
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
  logic              frame_start, testpat_q, testpat_d;
  logic [2:0]        bar_rgb;
`endif

  assign line_end  = (hcnt_q == HC_W'(H_TOTAL - 1));
  assign frame_end = line_end && (vcnt_q == VC_W'(V_TOTAL - 1));

  // FSM state register
  always_ff @(posedge hclk) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: start on en, stop only after the last clock of a frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_end && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run = (state_q == RUN);
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
    frame_start = en && (!run || frame_end);
`endif
  end

  // Raster counters and the undelayed (stage 0) timing attributes
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (!run) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (line_end) begin
      hcnt_d = '0;
      vcnt_d = frame_end ? '0 : vcnt_q + 1'b1;
    end
    tim_idle    = '0;
    tim_idle.hb = 1'b1;
    tim_idle.vb = 1'b1;
    tim_p0      = tim_idle;
    tim_p0.act  = run && (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
    tim_p0.hs   = run && (int'(hcnt_q) >= H_SYNC_START) && (int'(hcnt_q) < H_SYNC_START + H_SYNC);
    tim_p0.vs   = run && (int'(vcnt_q) >= V_SYNC_START) && (int'(vcnt_q) < V_SYNC_START + V_SYNC);
    tim_p0.hb   = !run || (int'(hcnt_q) >= H_ACTIVE);
    tim_p0.vb   = !run || (int'(vcnt_q) >= V_ACTIVE);
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
    tim_p0.tp   = testpat_q;
    tim_p0.bar  = 3'((int'(hcnt_q) * 8) / H_ACTIVE);
    testpat_d   = frame_start ? testpat : testpat_q;
    sfetch      = tim_p0.act && !testpat_q;
`else
    sfetch      = tim_p0.act;
`endif
    snextframe  = !tim_p0.vs;
  end

  // Delay line matching the VDMA fetch latency
  always_comb begin
    dly_d[0] = tim_p0;
    for (int i = 1; i < FETCH_LAT; i++) dly_d[i] = dly_q[i-1];
    tap = dly_q[FETCH_LAT-1];
  end

  // Sample stage: pixel capture, output polarity and underflow (set beats clear)
  always_comb begin
    video_r_d = '0;
    video_g_d = '0;
    video_b_d = '0;
    miss      = tap.act && !svalid;
    if (tap.act && svalid) begin
      video_r_d = sdata[PIXEL_W-1 -: R_W];
      video_g_d = sdata[G_W+B_W-1 -: G_W];
      video_b_d = sdata[B_W-1:0];
    end
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
    case (tap.bar)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
    if (tap.tp) miss = 1'b0;
    if (tap.act && tap.tp) begin
      video_r_d = {R_W{bar_rgb[2]}};
      video_g_d = {G_W{bar_rgb[1]}};
      video_b_d = {B_W{bar_rgb[0]}};
    end
`endif
    hsync_d        = tap.hs ? HS_ON : ~HS_ON;
    vsync_d        = tap.vs ? VS_ON : ~VS_ON;
    hblank_d       = tap.hb;
    vblank_d       = tap.vb;
    active_video_d = tap.act;
    underflow_d    = miss ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
  end

  // Counters, delay line and output register; reset aborts any frame in flight
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      hcnt_q         <= '0;
      vcnt_q         <= '0;
      for (int i = 0; i < FETCH_LAT; i++) dly_q[i] <= tim_idle;
      video_r_q      <= '0;
      video_g_q      <= '0;
      video_b_q      <= '0;
      hsync_q        <= ~HS_ON;
      vsync_q        <= ~VS_ON;
      hblank_q       <= 1'b1;
      vblank_q       <= 1'b1;
      active_video_q <= 1'b0;
      underflow_q    <= 1'b0;
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
      testpat_q      <= 1'b0;
`endif
    end else begin
      hcnt_q         <= hcnt_d;
      vcnt_q         <= vcnt_d;
      for (int i = 0; i < FETCH_LAT; i++) dly_q[i] <= dly_d[i];
      video_r_q      <= video_r_d;
      video_g_q      <= video_g_d;
      video_b_q      <= video_b_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      hblank_q       <= hblank_d;
      vblank_q       <= vblank_d;
      active_video_q <= active_video_d;
      underflow_q    <= underflow_d;
`ifdef VIDEO_TIMING_OUT_TESTPAT_EN
      testpat_q      <= testpat_d;
`endif
    end
  end

  assign video_r      = video_r_q;
  assign video_g      = video_g_q;
  assign video_b      = video_b_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign hblank       = hblank_q;
  assign vblank       = vblank_q;
  assign active_video = active_video_q;
  assign underflow    = underflow_q;

endmodule
